multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle sequencer for the 18-bit processor. It owns the instruction register, the FSM and the CMP flag register. Each cycle it drives the PC-update, register-file, ALU and data-memory strobes so that one instruction runs over 3–5 cycles against single-ported synchronous memories. It sits between the PC/instruction memory and the register file/ALU/data-memory datapath, and replaces purely combinational decode.

## Interface
- MEM_TIMEOUT, 15: maximum cycles MEM waits for DataReady before bus error (1–255).
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- InstrData  in  18  instruction memory read data; valid in the cycle after InstrRead.
- below, equal, above  in  1 each  ALU comparator of Src1 vs Src2; valid during EXECUTE.
- DataReady  in  1  data memory completion, sampled in MEM.
- InstrRead  out  1  instruction fetch strobe.
- PCWrite  out  1  PC load enable.
- PCSel  out  1  0 = PC+1, 1 = JumpAddress.
- JumpAddress  out  14  IR[13:0].
- isImm  out  1  ALU B operand = Imm.
- Imm  out  6  IR[5:0].
- ALUControl  out  2  00 add, 01 and, 10 nand, 11 nor.
- Src1, Src2, Dst  out  4 each  register file indices.
- RegWrite  out  1  register file write enable.
- MemToReg  out  1  writeback source is data memory.
- DataAddr  out  10  IR[9:0].
- DataRead, DataWrite  out  1 each  data memory strobes.
- Halted, IllegalOp, BusError  out  1 each  sticky status.
- State  out  3  current FSM state encoding.

## Operation
- Opcode = IR[17:14]: 0 ADD, 1 ADDI, 2 AND, 3 ANDI, 4 NAND, 5 NOR, 6 LD, 7 ST, 8 JMP, 9 CMP, A JE, B JA, C JB, D JAE, E JBE, F illegal.
- Fields: Dst = IR[13:10], Src1 = IR[9:6], Src2 = IR[3:0]. ST reads IR[13:10] on Src1. LD/ST address = IR[9:0].
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- FETCH: InstrRead=1. Next state DECODE.
- DECODE: IR <= InstrData. PCWrite=1, PCSel=0. Next state EXECUTE.
- EXECUTE: field outputs decoded from IR.
  - ALU ops go to WRITEBACK.
  - LD/ST go to MEM.
  - CMP: flags {b,e,a} <= {below,equal,above}, then FETCH.
  - JMP: PCWrite=1, PCSel=1, then FETCH.
  - Conditional jumps use the latched flags, not the live inputs. JE uses e, JA uses a, JB uses b, JAE uses a|e, JBE uses b|e. If taken, PCWrite=1 and PCSel=1. Either way, next state FETCH.
  - Opcode F: IllegalOp <= 1, next state HALT.
- MEM: LD holds DataRead=1, ST holds DataWrite=1, until DataReady.
  - LD on DataReady goes to WRITEBACK. ST on DataReady goes to FETCH.
  - A wait counter clears on MEM entry. If MEM_TIMEOUT cycles elapse without DataReady: BusError <= 1, strobes drop, next state HALT.
- WRITEBACK: RegWrite=1. MemToReg=1 for LD only. Next state FETCH.
- HALT: all strobes 0, Halted=1. Only Reset exits.
- Outside the states named above, every field output and strobe is 0.

## Timing
- Reset (any state, including MEM wait or HALT) forces on the next edge: State=FETCH, IR=0, flags=0, wait counter=0, and IllegalOp, BusError, Halted cleared.
  - All strobes and field outputs are 0 during the Reset cycle.
  - InstrRead=1 in the first cycle after Reset deasserts.
- Latency, zero-wait memory:
  - ALU ops: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - JMP, CMP, conditional jumps: 3 cycles.
  - Each DataReady wait cycle adds 1 to LD/ST.
- PC+1 is written in DECODE. A taken jump overwrites it in EXECUTE, so the final PC equals JumpAddress.
- A CMP immediately followed by a branch sees the flags written in CMP's EXECUTE.
- DataReady high on the same cycle the counter reaches MEM_TIMEOUT counts as success.
- DataReady outside MEM is ignored.
- All strobes are Moore outputs of State and IR, except MEM exit, which depends on DataReady.

## Test plan
- Reset, then ADDI R1,R2,#5 (0x0????) with zero-wait memory -> states 0,1,2,4. RegWrite=1 only in cycle 4, isImm=1, Imm=5, Dst=1, Src1=2.
- LD R3,[0x155] with DataReady delayed 3 cycles -> DataRead high for 4 MEM cycles. WRITEBACK has MemToReg=1 and Dst=3. Total 8 cycles.
- CMP with equal=1, then JE 0x0100 -> PCWrite in JE's DECODE (PCSel=0) and EXECUTE (PCSel=1), JumpAddress=0x0100. Repeat with above=1 -> only the PCSel=0 write.
- ST with DataReady never asserted, MEM_TIMEOUT=15 -> BusError=1 after 15 MEM cycles, State=HALT, DataWrite=0. Reset clears BusError and resumes at FETCH.
- Opcode 0xF -> IllegalOp=1, Halted=1 from the cycle after EXECUTE, no RegWrite/DataWrite/PCSel=1 pulses.
- Reset asserted mid-MEM of an LD -> next cycle State=FETCH, DataRead=0, no WRITEBACK occurs.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer: owns IR, control FSM and CMP flags, and
// drives PC, register-file, ALU and data-memory strobes each cycle.
//
// Ports:
//   Clock, Reset              clock, synchronous active-high reset
//   InstrData                 instruction read data (valid in DECODE)
//   below, equal, above       comparator inputs, sampled by CMP
//   DataReady                 data memory completion (used in MEM)
//   InstrRead, PCWrite, PCSel fetch strobe and PC update controls
//   JumpAddress, isImm, Imm   jump target and immediate operand
//   ALUControl                00 add, 01 and, 10 nand, 11 nor
//   Src1, Src2, Dst           register file indices
//   RegWrite, MemToReg        writeback enable and source select
//   DataAddr                  data memory address
//   DataRead, DataWrite       data memory strobes
//   Halted, IllegalOp         sticky status
//   BusError                  sticky status
//   State                     current FSM state
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [17:0] InstrData,
  input  logic        below,
  input  logic        equal,
  input  logic        above,
  input  logic        DataReady,
  output logic        InstrRead,
  output logic        PCWrite,
  output logic        PCSel,
  output logic [13:0] JumpAddress,
  output logic        isImm,
  output logic [5:0]  Imm,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Src1,
  output logic [3:0]  Src2,
  output logic [3:0]  Dst,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [9:0]  DataAddr,
  output logic        DataRead,
  output logic        DataWrite,
  output logic        Halted,
  output logic        IllegalOp,
  output logic        BusError,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [17:0] ir_q;
  logic [2:0]  flags_q;
  logic [7:0]  wait_q;
  logic        halted_q;
  logic        illegal_q;
  logic        bus_err_q;

  logic [3:0]  op;
  logic        is_alu;
  logic        is_mem;
  logic        is_ld;
  logic        is_st;
  logic        is_ill;
  logic        take;
  logic        mem_tmo;
  logic        fld_en;

  // flags_q = {b, e, a}
  logic fb, fe, fa;

  assign op      = ir_q[17:14];
  assign is_alu  = op < 4'd6;
  assign is_ld   = op == 4'd6;
  assign is_st   = op == 4'd7;
  assign is_mem  = is_ld | is_st;
  assign is_ill  = op == 4'hF;
  assign fb      = flags_q[2];
  assign fe      = flags_q[1];
  assign fa      = flags_q[0];
  // Last allowed wait cycle; DataReady here still succeeds.
  assign mem_tmo = !DataReady && (wait_q == WAIT_LAST);

  always_comb begin
    take = 1'b0;
    case (op)
      4'h8:    take = 1'b1;
      4'hA:    take = fe;
      4'hB:    take = fa;
      4'hC:    take = fb;
      4'hD:    take = fa | fe;
      4'hE:    take = fb | fe;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      flags_q   <= '0;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        ir_q <= InstrData;
      if (state_q == S_EXEC && op == 4'h9)
        flags_q <= {below, equal, above};
      if (state_q == S_MEM)
        wait_q <= wait_q + 8'd1;
      else
        wait_q <= '0;
      if (state_q == S_EXEC && is_ill)
        illegal_q <= 1'b1;
      if (state_q == S_MEM && mem_tmo)
        bus_err_q <= 1'b1;
      if (state_d == S_HALT)
        halted_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_alu:  state_d = S_WB;
          is_mem:  state_d = S_MEM;
          is_ill:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (DataReady)
          state_d = is_ld ? S_WB : S_FETCH;
        else if (mem_tmo)
          state_d = S_HALT;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    InstrRead   = 1'b0;
    PCWrite     = 1'b0;
    PCSel       = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    DataRead    = 1'b0;
    DataWrite   = 1'b0;
    fld_en      = 1'b0;
    JumpAddress = '0;
    isImm       = 1'b0;
    Imm         = '0;
    ALUControl  = 2'b00;
    Src1        = '0;
    Src2        = '0;
    Dst         = '0;
    DataAddr    = '0;
    if (!Reset) begin
      unique case (state_q)
        S_FETCH:  InstrRead = 1'b1;
        S_DECODE: PCWrite = 1'b1;
        S_EXEC: begin
          fld_en  = 1'b1;
          PCWrite = take;
          PCSel   = take;
        end
        S_MEM: begin
          fld_en    = 1'b1;
          DataRead  = is_ld;
          DataWrite = is_st;
        end
        S_WB: begin
          fld_en   = 1'b1;
          RegWrite = 1'b1;
          MemToReg = is_ld;
        end
        default: fld_en = 1'b0;
      endcase
    end
    if (fld_en) begin
      JumpAddress = ir_q[13:0];
      Imm         = ir_q[5:0];
      isImm       = (op == 4'd1) || (op == 4'd3);
      Dst         = ir_q[13:10];
      Src1        = is_st ? ir_q[13:10] : ir_q[9:6];
      Src2        = ir_q[3:0];
      DataAddr    = ir_q[9:0];
      case (op)
        4'd2, 4'd3: ALUControl = 2'b01;
        4'd4:       ALUControl = 2'b10;
        4'd5:       ALUControl = 2'b11;
        default:    ALUControl = 2'b00;
      endcase
    end
  end

  assign Halted    = halted_q;
  assign IllegalOp = illegal_q;
  assign BusError  = bus_err_q;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level model of the
// expected per-cycle outputs plus directed literal checks.
module tb_multicycle_sequencer;

  localparam int MT = 15;

  logic        Clock;
  logic        Reset;
  logic [17:0] InstrData;
  logic        below, equal, above;
  logic        DataReady;
  logic        InstrRead, PCWrite, PCSel;
  logic [13:0] JumpAddress;
  logic        isImm;
  logic [5:0]  Imm;
  logic [1:0]  ALUControl;
  logic [3:0]  Src1, Src2, Dst;
  logic        RegWrite, MemToReg;
  logic [9:0]  DataAddr;
  logic        DataRead, DataWrite;
  logic        Halted, IllegalOp, BusError;
  logic [2:0]  State;

  multicycle_sequencer #(.MEM_TIMEOUT(MT)) dut (
    .Clock(Clock), .Reset(Reset), .InstrData(InstrData),
    .below(below), .equal(equal), .above(above),
    .DataReady(DataReady), .InstrRead(InstrRead),
    .PCWrite(PCWrite), .PCSel(PCSel),
    .JumpAddress(JumpAddress), .isImm(isImm), .Imm(Imm),
    .ALUControl(ALUControl), .Src1(Src1), .Src2(Src2),
    .Dst(Dst), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .DataAddr(DataAddr), .DataRead(DataRead),
    .DataWrite(DataWrite), .Halted(Halted),
    .IllegalOp(IllegalOp), .BusError(BusError),
    .State(State)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ir, pcw, pcs;
    logic [13:0] ja;
    logic        isi;
    logic [5:0]  imm;
    logic [1:0]  alu;
    logic [3:0]  s1, s2, d;
    logic        rw, m2r;
    logic [9:0]  da;
    logic        dr, dw, hl, il, be;
  } rec_t;

  int checks = 0;
  int errors = 0;
  int ncyc, ndr, ndw, nrw, npcs;
  rec_t last;

  // model state
  logic [13:0] mpc = '0;
  logic [2:0]  mfl = '0;
  logic        mhl = 0, mil = 0, mbe = 0;
  logic [2:0]  nxt = '0;

  // PC register as the surrounding datapath would build it
  logic [13:0] pc_reg = '0;
  always @(posedge Clock)
    if (PCWrite === 1'b1)
      pc_reg <= PCSel ? JumpAddress : pc_reg + 14'd1;

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  function automatic rec_t base(input logic [2:0] st);
    rec_t e;
    e = '0;
    e.st = st;
    e.hl = mhl;
    e.il = mil;
    e.be = mbe;
    return e;
  endfunction

  function automatic rec_t fld(input logic [17:0] ins,
                               input logic [2:0] st);
    rec_t e;
    logic [3:0] op;
    op = ins[17:14];
    e = base(st);
    e.ja  = ins[13:0];
    e.imm = ins[5:0];
    e.isi = (op == 4'd1) || (op == 4'd3);
    e.d   = ins[13:10];
    e.s1  = (op == 4'd7) ? ins[13:10] : ins[9:6];
    e.s2  = ins[3:0];
    e.da  = ins[9:0];
    if (op == 4'd2 || op == 4'd3) e.alu = 2'b01;
    else if (op == 4'd4) e.alu = 2'b10;
    else if (op == 4'd5) e.alu = 2'b11;
    else e.alu = 2'b00;
    return e;
  endfunction

  function automatic rec_t obs();
    rec_t o;
    o.st = State; o.ir = InstrRead;
    o.pcw = PCWrite; o.pcs = PCSel;
    o.ja = JumpAddress; o.isi = isImm; o.imm = Imm;
    o.alu = ALUControl; o.s1 = Src1; o.s2 = Src2;
    o.d = Dst; o.rw = RegWrite; o.m2r = MemToReg;
    o.da = DataAddr; o.dr = DataRead; o.dw = DataWrite;
    o.hl = Halted; o.il = IllegalOp; o.be = BusError;
    return o;
  endfunction

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input rec_t e, input logic chk,
                      input logic rst, input logic [17:0] ins,
                      input logic rdy, input logic [2:0] c);
    rec_t o;
    @(negedge Clock);
    Reset = rst;
    InstrData = ins;
    DataReady = rdy;
    {below, equal, above} = c;
    #1;
    o = obs();
    last = o;
    ncyc++;
    if (o.dr === 1'b1) ndr++;
    if (o.dw === 1'b1) ndw++;
    if (o.rw === 1'b1) nrw++;
    if (o.pcs === 1'b1) npcs++;
    if (chk) begin
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h",
                 $time, o, e);
      end
      if (!rst && e.st == 3'd0 && e.ir) begin
        checks++;
        if (pc_reg !== mpc) begin
          errors++;
          $display("FAIL pc_at_fetch got=%h exp=%h", pc_reg, mpc);
        end
      end
    end
  endtask

  task automatic do_rst();
    rec_t e;
    e = base(nxt);
    step(e, 1'b1, 1'b1, 18'($urandom), 1'($urandom),
         3'($urandom));
    mhl = 0; mil = 0; mbe = 0;
    mfl = '0;
    nxt = 3'd0;
  endtask

  task automatic halt_cyc(input int n);
    for (int i = 0; i < n; i++)
      step(base(3'd5), 1'b1, 1'b0, 18'($urandom), 1'($urandom),
           3'($urandom));
  endtask

  // One instruction: w = DataReady wait cycles in MEM,
  // cx = comparator value in EXECUTE, rmem = MEM cycle to reset in.
  task automatic exec(input logic [17:0] ins, input int w,
                      input logic [2:0] cx, input int rmem);
    logic [3:0] op;
    rec_t e;
    logic tk;
    op = ins[17:14];
    e = base(3'd0);
    e.ir = 1'b1;
    step(e, 1'b1, 1'b0, 18'($urandom), 1'($urandom),
         3'($urandom));
    e = base(3'd1);
    e.pcw = 1'b1;
    step(e, 1'b1, 1'b0, ins, 1'($urandom), 3'($urandom));
    mpc = mpc + 14'd1;
    case (op)
      4'h8:    tk = 1'b1;
      4'hA:    tk = mfl[1];
      4'hB:    tk = mfl[0];
      4'hC:    tk = mfl[2];
      4'hD:    tk = mfl[0] | mfl[1];
      4'hE:    tk = mfl[2] | mfl[1];
      default: tk = 1'b0;
    endcase
    e = fld(ins, 3'd2);
    if (tk) begin
      e.pcw = 1'b1;
      e.pcs = 1'b1;
    end
    step(e, 1'b1, 1'b0, 18'($urandom), 1'($urandom), cx);
    if (tk) mpc = ins[13:0];
    if (op == 4'h9) mfl = cx;
    if (op == 4'hF) begin
      mil = 1; mhl = 1; nxt = 3'd5;
      return;
    end
    if (op >= 4'd8) begin
      nxt = 3'd0;
      return;
    end
    if (op <= 4'd5) begin
      e = fld(ins, 3'd4);
      e.rw = 1'b1;
      step(e, 1'b1, 1'b0, 18'($urandom), 1'($urandom),
           3'($urandom));
      nxt = 3'd0;
      return;
    end
    for (int k = 0; k < MT; k++) begin
      if (k == rmem) begin
        nxt = 3'd3;
        do_rst();
        return;
      end
      e = fld(ins, 3'd3);
      e.dr = (op == 4'd6);
      e.dw = (op == 4'd7);
      step(e, 1'b1, 1'b0, 18'($urandom), 1'(k >= w),
           3'($urandom));
      if (k >= w) begin
        if (op == 4'd6) begin
          e = fld(ins, 3'd4);
          e.rw = 1'b1;
          e.m2r = 1'b1;
          step(e, 1'b1, 1'b0, 18'($urandom), 1'($urandom),
               3'($urandom));
        end
        nxt = 3'd0;
        return;
      end
    end
    mbe = 1; mhl = 1; nxt = 3'd5;
  endtask

  task automatic zero_cnt();
    ncyc = 0; ndr = 0; ndw = 0; nrw = 0; npcs = 0;
  endtask

  initial begin
    int r, w;
    logic [3:0] op;
    Reset = 1; InstrData = '0; DataReady = 0;
    below = 0; equal = 0; above = 0;
    zero_cnt();
    step(base(3'd0), 1'b0, 1'b1, '0, 1'b0, 3'd0);
    do_rst();

    // ADDI R1,R2,#5
    zero_cnt();
    exec(18'h04485, 0, 3'd0, -1);
    lit("addi_cycles", ncyc, 4);
    lit("addi_rw", last.rw, 1);
    lit("addi_dst", last.d, 1);
    lit("addi_src1", last.s1, 2);
    lit("addi_imm", last.imm, 5);
    lit("addi_isimm", last.isi, 1);

    // LD R3,[0x155], 3 wait cycles
    zero_cnt();
    exec(18'h18D55, 3, 3'd0, -1);
    lit("ld_cycles", ncyc, 8);
    lit("ld_dataread", ndr, 4);
    lit("ld_memtoreg", last.m2r, 1);
    lit("ld_dst", last.d, 3);

    // CMP equal then JE taken; CMP above then JE not taken
    exec(18'h24000, 0, 3'b010, -1);
    exec(18'h28100, 0, 3'b000, -1);
    @(posedge Clock); #1;
    lit("je_taken_pc", pc_reg, 14'h100);
    exec(18'h24000, 0, 3'b001, -1);
    exec(18'h28100, 0, 3'b111, -1);
    @(posedge Clock); #1;
    lit("je_nottaken_pc", pc_reg, 14'h102);

    // ST with no DataReady -> bus error
    zero_cnt();
    exec(18'h1C2AA, 1000, 3'd0, -1);
    halt_cyc(2);
    lit("st_buserror", last.be, 1);
    lit("st_state", last.st, 5);
    lit("st_datawrite", last.dw, 0);
    lit("st_wr_cycles", ndw, MT);
    do_rst();

    // illegal opcode
    zero_cnt();
    exec(18'h3C123, 0, 3'd0, -1);
    halt_cyc(2);
    lit("ill_flag", last.il, 1);
    lit("ill_halted", last.hl, 1);
    lit("ill_no_rw", nrw, 0);
    lit("ill_no_dw", ndw, 0);
    lit("ill_no_pcs", npcs, 0);
    do_rst();

    // reset in the middle of an LD wait
    exec(18'h18D55, 10, 3'd0, 2);
    @(posedge Clock); #1;
    lit("midrst_state", State, 0);
    lit("midrst_dr", DataRead, 0);
    exec(18'h04485, 0, 3'd0, -1);

    // LD succeeding on the last allowed wait cycle
    exec(18'h18D55, MT - 1, 3'd0, -1);
    lit("ld_edge_nobuserr", last.be, 0);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 2) != 0)
        op = 4'h9;
      r = $urandom_range(0, 9);
      if (r < 6) w = r;
      else if (r < 8) w = 0;
      else if (r == 8) w = MT - 1;
      else w = MT + 5;
      exec({op, 14'($urandom)}, w, 3'($urandom), -1);
      if (mhl) begin
        halt_cyc(2);
        do_rst();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
